// File: rtl/drawing_engine.sv
// Cell-based drawing engine: mouse cell + buttons -> VGA pixel writes, square brush, clear.
// Define DRAWING_ENGINE_ERASE_EN to let the right button erase with BG_COLOUR.
module drawing_engine #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int CELL_DIM      = 5,
    parameter int BRUSH_MAX     = 4,
    parameter int COLOUR_BITS   = 3,
    parameter int BG_COLOUR     = 0,
    localparam int CX_BITS = $clog2(SCREEN_WIDTH / CELL_DIM),
    localparam int CY_BITS = $clog2(SCREEN_HEIGHT / CELL_DIM),
    localparam int X_BITS  = $clog2(SCREEN_WIDTH),
    localparam int Y_BITS  = $clog2(SCREEN_HEIGHT),
    localparam int B_BITS  = $clog2(BRUSH_MAX + 1)
) (
    input  logic                   iClk,
    input  logic                   iResetn,
    input  logic [CX_BITS-1:0]     iX_cell,
    input  logic [CY_BITS-1:0]     iY_cell,
    input  logic [COLOUR_BITS-1:0] iColour,
    input  logic [B_BITS-1:0]      iBrush,
    input  logic                   iLeftbtn,
    input  logic                   iRightbtn,
    input  logic                   iClear,
    input  logic                   iTxDone,
    output logic                   oStartTransmission,
    output logic                   oMouseEnable,
    output logic [X_BITS-1:0]      oX_pixel,
    output logic [Y_BITS-1:0]      oY_pixel,
    output logic [COLOUR_BITS-1:0] oColour,
    output logic                   oPlot,
    output logic                   oBusy
);

    localparam int SIDE_MAX = BRUSH_MAX * CELL_DIM;
    localparam int WH_MAX   = (SCREEN_WIDTH > SCREEN_HEIGHT) ? SCREEN_WIDTH : SCREEN_HEIGHT;
    localparam int CNT_LIM  = (WH_MAX > SIDE_MAX) ? WH_MAX : SIDE_MAX;
    localparam int CW       = $clog2(CNT_LIM);

    localparam logic [COLOUR_BITS-1:0] BG   = COLOUR_BITS'(BG_COLOUR);
    localparam logic [B_BITS-1:0]      BMAX = B_BITS'(BRUSH_MAX);

`ifdef DRAWING_ENGINE_ERASE_EN
    localparam logic ERASE_EN = 1'b1;
`else
    localparam logic ERASE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_PAINT, S_MDIS, S_CLEAR, S_MEN
    } state_t;

    state_t                 state_q, state_d;
    logic                   entry_q, entry_d;
    logic [CX_BITS-1:0]     cx_q, cx_d;
    logic [CY_BITS-1:0]     cy_q, cy_d;
    logic [COLOUR_BITS-1:0] col_q, col_d;
    logic [B_BITS-1:0]      bsz_q, bsz_d;
    logic [CW-1:0]          offx_q, offx_d;
    logic [CW-1:0]          offy_q, offy_d;
    logic [CX_BITS-1:0]     last_x_q, last_x_d;
    logic [CY_BITS-1:0]     last_y_q, last_y_d;
    logic                   last_vld_q, last_vld_d;
    logic                   lbtn_q, lbtn_d;
    logic                   rbtn_q, rbtn_d;
    logic [X_BITS-1:0]      px_q, px_d;
    logic [Y_BITS-1:0]      py_q, py_d;
    logic [COLOUR_BITS-1:0] ocol_q, ocol_d;
    logic                   plot_q, plot_d;
    logic                   start_q, start_d;
    logic                   men_q, men_d;
    logic                   busy_q, busy_d;

    logic                   r_act;
    logic                   moved;
    logic                   stamp;
    logic [COLOUR_BITS-1:0] stamp_col;
    logic [B_BITS-1:0]      bclamp;
    logic [31:0]            side_m1;
    logic [31:0]            px_full;
    logic [31:0]            py_full;
    logic                   x_end;
    logic                   y_end;

    always_comb begin
        r_act   = iRightbtn & ERASE_EN;
        moved   = !last_vld_q || (iX_cell != last_x_q) || (iY_cell != last_y_q);
        side_m1 = 32'(bsz_q) * 32'(CELL_DIM) - 32'd1;
        px_full = 32'(cx_q) * 32'(CELL_DIM) + 32'(offx_q);
        py_full = 32'(cy_q) * 32'(CELL_DIM) + 32'(offy_q);
        if (iBrush == '0) begin
            bclamp = B_BITS'(1);
        end else if (iBrush > BMAX) begin
            bclamp = BMAX;
        end else begin
            bclamp = iBrush;
        end
    end

    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        col_d      = col_q;
        bsz_d      = bsz_q;
        offx_d     = offx_q;
        offy_d     = offy_q;
        last_x_d   = last_x_q;
        last_y_d   = last_y_q;
        last_vld_d = last_vld_q;
        px_d       = px_q;
        py_d       = py_q;
        ocol_d     = ocol_q;
        men_d      = men_q;
        plot_d     = 1'b0;
        start_d    = 1'b0;
        busy_d     = (state_q != S_IDLE);
        lbtn_d     = iLeftbtn;
        rbtn_d     = r_act;
        stamp      = 1'b0;
        stamp_col  = iColour;
        x_end      = 1'b0;
        y_end      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (iClear) begin
                    state_d = S_MDIS;
                end else if (iLeftbtn) begin
                    stamp = !lbtn_q || moved;
                end else if (r_act && (!rbtn_q || moved)) begin
                    stamp     = 1'b1;
                    stamp_col = BG;
                end
                if (stamp) begin
                    state_d    = S_PAINT;
                    cx_d       = iX_cell;
                    cy_d       = iY_cell;
                    col_d      = stamp_col;
                    bsz_d      = bclamp;
                    last_x_d   = iX_cell;
                    last_y_d   = iY_cell;
                    last_vld_d = 1'b1;
                    offx_d     = '0;
                    offy_d     = '0;
                end
            end
            S_PAINT: begin
                px_d   = px_full[X_BITS-1:0];
                py_d   = py_full[Y_BITS-1:0];
                ocol_d = col_q;
                plot_d = (px_full < 32'(SCREEN_WIDTH)) && (py_full < 32'(SCREEN_HEIGHT));
                x_end  = (32'(offx_q) == side_m1);
                y_end  = (32'(offy_q) == side_m1);
            end
            S_MDIS: begin
                men_d   = 1'b0;
                start_d = entry_q;
                if (!entry_q && iTxDone) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                px_d   = offx_q[X_BITS-1:0];
                py_d   = offy_q[Y_BITS-1:0];
                ocol_d = BG;
                plot_d = 1'b1;
                x_end  = (32'(offx_q) == 32'(SCREEN_WIDTH - 1));
                y_end  = (32'(offy_q) == 32'(SCREEN_HEIGHT - 1));
            end
            S_MEN: begin
                men_d   = 1'b1;
                start_d = entry_q;
                if (!entry_q && iTxDone) begin
                    state_d    = S_IDLE;
                    last_vld_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shared X-fastest scan for both the brush square and the full-frame clear
        if (state_q == S_PAINT || state_q == S_CLEAR) begin
            if (x_end) begin
                offx_d = '0;
                if (y_end) begin
                    offy_d  = '0;
                    state_d = (state_q == S_PAINT) ? S_IDLE : S_MEN;
                end else begin
                    offy_d = offy_q + CW'(1);
                end
            end else begin
                offx_d = offx_q + CW'(1);
            end
        end

        entry_d = (state_d != state_q);
    end

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            state_q    <= S_IDLE;
            entry_q    <= 1'b0;
            cx_q       <= '0;
            cy_q       <= '0;
            col_q      <= '0;
            bsz_q      <= '0;
            offx_q     <= '0;
            offy_q     <= '0;
            last_x_q   <= '0;
            last_y_q   <= '0;
            last_vld_q <= 1'b0;
            lbtn_q     <= 1'b0;
            rbtn_q     <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            ocol_q     <= '0;
            plot_q     <= 1'b0;
            start_q    <= 1'b0;
            men_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            col_q      <= col_d;
            bsz_q      <= bsz_d;
            offx_q     <= offx_d;
            offy_q     <= offy_d;
            last_x_q   <= last_x_d;
            last_y_q   <= last_y_d;
            last_vld_q <= last_vld_d;
            lbtn_q     <= lbtn_d;
            rbtn_q     <= rbtn_d;
            px_q       <= px_d;
            py_q       <= py_d;
            ocol_q     <= ocol_d;
            plot_q     <= plot_d;
            start_q    <= start_d;
            men_q      <= men_d;
            busy_q     <= busy_d;
        end
    end

    assign oStartTransmission = start_q;
    assign oMouseEnable       = men_q;
    assign oX_pixel           = px_q;
    assign oY_pixel           = py_q;
    assign oColour            = ocol_q;
    assign oPlot              = plot_q;
    assign oBusy              = busy_q;

endmodule

// File: tb/tb_drawing_engine.sv
// Bench for drawing_engine on a 40x30 screen: stamp table, hand sequences, random vs model.
// Honours DRAWING_ENGINE_ERASE_EN for right-button expectations.
module tb_drawing_engine;

    localparam int W  = 40;
    localparam int H  = 30;
    localparam int CD = 5;
    localparam int BM = 4;
    localparam int BG = 2;

`ifdef DRAWING_ENGINE_ERASE_EN
    localparam bit ERASE = 1'b1;
`else
    localparam bit ERASE = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [2:0] x_cell;
    logic [2:0] y_cell;
    logic [2:0] colour;
    logic [2:0] brush;
    logic       lbtn;
    logic       rbtn;
    logic       clr;
    logic       txdone;
    logic       start;
    logic       men;
    logic [5:0] px;
    logic [4:0] py;
    logic [2:0] pcol;
    logic       plot;
    logic       busy;

    drawing_engine #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .CELL_DIM     (CD),
        .BRUSH_MAX    (BM),
        .COLOUR_BITS  (3),
        .BG_COLOUR    (BG)
    ) dut (
        .iClk              (clk),
        .iResetn           (rst_n),
        .iX_cell           (x_cell),
        .iY_cell           (y_cell),
        .iColour           (colour),
        .iBrush            (brush),
        .iLeftbtn          (lbtn),
        .iRightbtn         (rbtn),
        .iClear            (clr),
        .iTxDone           (txdone),
        .oStartTransmission(start),
        .oMouseEnable      (men),
        .oX_pixel          (px),
        .oY_pixel          (py),
        .oColour           (pcol),
        .oPlot             (plot),
        .oBusy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_start"}, start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_xy"}, {px, py}, 0);
        check({tag, "_col"}, pcol, 0);
        check({tag, "_men"}, men, 1);
    endtask

    typedef struct {
        int cx, cy, br, col;
        bit left, right;
        int plots, cycles, fx, fy, lx, ly, ecol;
    } vec_t;

    typedef struct {
        bit p;
        int x, y, c;
    } px_t;

    vec_t vt[7];
    px_t  mq[$];

    int np, nb, badc, fx, fy, lx, ly, first_k, errs, found;

    initial begin
        vt[0] = '{0, 0, 1, 5, 1'b1, 1'b0, 25, 25, 0, 0, 4, 4, 5};
        vt[1] = '{7, 5, 2, 3, 1'b1, 1'b0, 25, 100, 35, 25, 39, 29, 3};
        vt[2] = '{1, 2, 0, 6, 1'b1, 1'b0, 25, 25, 5, 10, 9, 14, 6};
        vt[3] = '{2, 1, 7, 1, 1'b1, 1'b0, 400, 400, 10, 5, 29, 24, 1};
        vt[4] = '{3, 3, 3, 7, 1'b0, 1'b1, ERASE ? 225 : 0, ERASE ? 225 : 0,
                  15, 15, 29, 29, BG};
        vt[5] = '{6, 4, 3, 4, 1'b1, 1'b0, 100, 225, 30, 20, 39, 29, 4};
        vt[6] = '{3, 3, 1, 7, 1'b1, 1'b1, 25, 25, 15, 15, 19, 19, 7};

        rst_n = 1'b0;
        x_cell = '0; y_cell = '0; colour = '0; brush = '0;
        lbtn = 1'b0; rbtn = 1'b0; clr = 1'b0; txdone = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table of single stamps
        for (int i = 0; i < 7; i++) begin
            x_cell = 3'(vt[i].cx); y_cell = 3'(vt[i].cy);
            brush = 3'(vt[i].br); colour = 3'(vt[i].col);
            lbtn = vt[i].left; rbtn = vt[i].right;
            np = 0; nb = 0; badc = 0; fx = -1; fy = -1; lx = -1; ly = -1;
            for (int k = 0; k < 420; k++) begin
                @(negedge clk);
                if (busy) nb++;
                if (plot) begin
                    if (np == 0) begin fx = px; fy = py; end
                    lx = px; ly = py;
                    if (pcol != 3'(vt[i].ecol)) badc++;
                    np++;
                end
            end
            lbtn = 1'b0; rbtn = 1'b0;
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_plots", i), np, vt[i].plots);
            check($sformatf("v%0d_busy", i), nb, vt[i].cycles);
            check($sformatf("v%0d_colour", i), badc, 0);
            if (vt[i].plots > 0) begin
                check($sformatf("v%0d_first", i), fx * 100 + fy, vt[i].fx * 100 + vt[i].fy);
                check($sformatf("v%0d_last", i), lx * 100 + ly, vt[i].lx * 100 + vt[i].ly);
            end
        end

        // Held button on a fixed cell stamps once; latency of one cycle
        x_cell = 3'd2; y_cell = 3'd2; brush = 3'd1; colour = 3'd4; lbtn = 1'b1;
        np = 0; first_k = -1; nb = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (plot) begin
                if (first_k < 0) first_k = k;
                np++;
            end
            if (k == 27) nb = busy;
        end
        check("hold_plots", np, 25);
        check("hold_latency", first_k, 2);
        check("hold_busy_26th", nb, 0);
        x_cell = 3'd3;
        np = 0; fx = -1; fy = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (plot) begin
                if (np == 0) begin fx = px; fy = py; end
                np++;
            end
        end
        check("move_plots", np, 25);
        check("move_first", fx * 100 + fy, 15 * 100 + 10);

        // Clear with left still held on the same cell
        clr = 1'b1;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge clk);
            if (start) begin found = 1; check("mdis_men", men, 0); end
        end
        check("mdis_start", found, 1);
        clr = 1'b0;
        np = 0; nb = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (plot) np++;
            if (busy) nb++;
        end
        check("mdis_wait_plots", np, 0);
        check("mdis_wait_busy", nb, 20);
        txdone = 1'b1;
        @(negedge clk);
        txdone = 1'b0;
        np = 0; errs = 0; badc = 0; found = 0; lx = -1; ly = -1;
        for (int k = 0; k < 1400 && found == 0; k++) begin
            if (k > 0) @(negedge clk);
            if (plot) begin
                if (px != 6'(np % W) || py != 5'(np / W)) errs++;
                if (pcol != 3'(BG)) badc++;
                lx = px; ly = py;
                np++;
            end
            if (start) begin found = 1; check("men_men", men, 1); end
        end
        check("clear_plots", np, W * H);
        check("clear_order", errs, 0);
        check("clear_colour", badc, 0);
        check("clear_last", lx * 100 + ly, (W - 1) * 100 + (H - 1));
        check("men_start", found, 1);
        np = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (plot || start) np++;
        end
        check("men_wait_quiet", np, 0);
        check("men_wait_busy", busy, 1);
        txdone = 1'b1;
        @(negedge clk);
        txdone = 1'b0;
        found = 0;
        for (int k = 0; k < 5 && found == 0; k++) begin
            @(negedge clk);
            if (!busy) found = 1;
        end
        check("clear_idle", found, 1);
        np = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (plot) np++;
        end
        check("restamp_after_clear", np, 25);
        lbtn = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a clear
        clr = 1'b1;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge clk);
            if (start) found = 1;
        end
        check("rst_seq_start", found, 1);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        txdone = 1'b1;
        @(negedge clk);
        txdone = 1'b0;
        repeat (100) @(negedge clk);
        check("rst_seq_plotting", plot, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midclear");
        @(negedge clk);
        rst_n = 1'b1;
        np = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (plot || start || busy) np++;
        end
        check("post_reset_quiet", np, 0);

        // Random stimulus against a pixel-list model
        begin
            int  m_busy, m_lx, m_ly;
            bit  m_lv, m_pl, m_pr;
            longint act, exp;
            px_t e;
            m_busy = 0; m_lx = 0; m_ly = 0;
            m_lv = 0; m_pl = 0; m_pr = 0;
            mq.delete();
            for (int cyc = 0; cyc < 6000; cyc++) begin
                @(negedge clk);
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    exp = {1'b1, e.p, e.p ? {6'(e.x), 5'(e.y), 3'(e.c)} : 14'd0};
                end else begin
                    exp = {1'b0, 1'b0, 14'd0};
                end
                act = {busy, plot, plot ? {px, py, pcol} : 14'd0};
                check($sformatf("rand_c%0d", cyc), act, exp);

                if (m_busy == 0) begin
                    bit go;
                    int colr, b, side;
                    bit mv;
                    go = 0; colr = colour;
                    mv = !m_lv || int'(x_cell) != m_lx || int'(y_cell) != m_ly;
                    if (lbtn) go = !m_pl || mv;
                    else if (ERASE && rbtn && (!m_pr || mv)) begin go = 1; colr = BG; end
                    if (go) begin
                        b = (brush == 0) ? 1 : ((int'(brush) > BM) ? BM : int'(brush));
                        side = b * CD;
                        for (int r = 0; r < side; r++) begin
                            for (int c = 0; c < side; c++) begin
                                e.x = int'(x_cell) * CD + c;
                                e.y = int'(y_cell) * CD + r;
                                e.c = colr;
                                e.p = (e.x < W) && (e.y < H);
                                mq.push_back(e);
                            end
                        end
                        m_busy = side * side;
                        m_lx = x_cell; m_ly = y_cell; m_lv = 1;
                    end
                end else begin
                    m_busy--;
                end
                m_pl = lbtn;
                m_pr = rbtn;

                if ($urandom_range(5) == 0) lbtn = ~lbtn;
                if ($urandom_range(5) == 0) rbtn = ~rbtn;
                if ($urandom_range(9) == 0) begin
                    x_cell = 3'($urandom_range(7));
                    y_cell = 3'($urandom_range(7));
                end
                colour = 3'($urandom_range(7));
                brush  = 3'($urandom_range(7));
                txdone = ($urandom_range(7) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
